// File: rtl/lamp_cmd_sequencer_pkg.sv
// Shared types and default timing constants for the lamp command sequencer.
package lighting_pkg;

  typedef enum logic [1:0] {
    B_IDLE,
    B_PRESSED,
    B_HELD
  } btn_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_RUN,
    T_DONE
  } tmr_state_t;

  localparam int DEF_DB_CYCLES   = 100;
  localparam int DEF_LONG_CYCLES = 3000;
  localparam int DEF_HOLD_CYCLES = 1000;

endpackage

// File: rtl/lamp_cmd_sequencer_if.sv
// Board/lamp-FSM side signals of the command sequencer.
interface lamp_cmd_sequencer_if;
  logic push;
  logic presence;
  logic enable;
  logic a;
  logic b;
  logic c;
  logic d;
  logic tmr_busy;

  modport master (
    output push, presence, enable,
    input  a, b, c, d, tmr_busy
  );

  modport slave (
    input  push, presence, enable,
    output a, b, c, d, tmr_busy
  );
endinterface

// File: rtl/lamp_cmd_sequencer_sync_debounce.sv
// 2-FF synchroniser followed by a stability counter for the push-button.
module sync_debounce
  import lighting_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic btn_db
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      btn_db <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      // The level flips on the DB_CYCLES-th consecutive differing cycle.
      if (s2 == btn_db) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        btn_db <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/lamp_cmd_sequencer.sv
// Turns a raw button and presence sensor into single-cycle event pulses
// for the lamp FSM: b (short press), a (long press), d (turn-on), c (timeout).
module lamp_cmd_sequencer
  import lighting_pkg::*;
#(
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int LONG_CYCLES = DEF_LONG_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input logic                 clk,
  input logic                 rst,
  lamp_cmd_sequencer_if.slave bus
);

  localparam int PW = $clog2(LONG_CYCLES + 1);
  localparam int TW = $clog2(HOLD_CYCLES + 1);
  localparam logic [PW-1:0] LONG_LAST = PW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES);

  logic btn_db;

  sync_debounce #(.DB_CYCLES(DB_CYCLES)) u_sync_debounce (
    .clk    (clk),
    .rst    (rst),
    .din    (bus.push),
    .btn_db (btn_db)
  );

  btn_state_t    btn_state, btn_state_nxt;
  logic [PW-1:0] press_cnt, press_cnt_nxt;
  logic          a_nxt, b_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_state <= B_IDLE;
      press_cnt <= '0;
    end else begin
      btn_state <= btn_state_nxt;
      press_cnt <= press_cnt_nxt;
    end
  end

  always_comb begin
    btn_state_nxt = btn_state;
    press_cnt_nxt = press_cnt;
    case (btn_state)
      B_IDLE: begin
        if (btn_db) begin
          btn_state_nxt = B_PRESSED;
          press_cnt_nxt = PW'(1);
        end
      end
      B_PRESSED: begin
        if (!btn_db) begin
          btn_state_nxt = B_IDLE;
          press_cnt_nxt = '0;
        end else begin
          press_cnt_nxt = press_cnt + PW'(1);
          if (press_cnt == LONG_LAST) btn_state_nxt = B_HELD;
        end
      end
      B_HELD: begin
        if (!btn_db) begin
          btn_state_nxt = B_IDLE;
          press_cnt_nxt = '0;
        end
      end
      default: begin
        btn_state_nxt = B_IDLE;
        press_cnt_nxt = '0;
      end
    endcase
  end

  // A release seen in the same cycle as the long threshold counts as short.
  always_comb begin
    a_nxt = 1'b0;
    b_nxt = 1'b0;
    if (btn_state == B_PRESSED) begin
      b_nxt = !btn_db;
      a_nxt = btn_db && (press_cnt == LONG_LAST);
    end
  end

  logic pres_s1, pres_s2, pres_q;
  logic enable_q;
  logic d_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pres_s1  <= 1'b0;
      pres_s2  <= 1'b0;
      pres_q   <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      pres_s1  <= bus.presence;
      pres_s2  <= pres_s1;
      pres_q   <= pres_s2;
      enable_q <= bus.enable;
    end
  end

  assign d_nxt = pres_s2 & ~pres_q;

  tmr_state_t    tmr_state, tmr_state_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic          c_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_state <= T_IDLE;
      tmr       <= '0;
    end else begin
      tmr_state <= tmr_state_nxt;
      tmr       <= tmr_nxt;
    end
  end

  always_comb begin
    tmr_state_nxt = tmr_state;
    tmr_nxt       = tmr;
    case (tmr_state)
      T_IDLE: begin
        if (bus.enable && !enable_q) begin
          tmr_state_nxt = T_RUN;
          tmr_nxt       = HOLD_LOAD;
        end
      end
      T_RUN: begin
        if (!bus.enable) begin
          tmr_state_nxt = T_IDLE;
          tmr_nxt       = '0;
        end else if (pres_s2) begin
          tmr_nxt = HOLD_LOAD;
        end else if (tmr == TW'(1)) begin
          tmr_state_nxt = T_DONE;
          tmr_nxt       = '0;
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      T_DONE: begin
        if (!bus.enable) tmr_state_nxt = T_IDLE;
      end
      default: begin
        tmr_state_nxt = T_IDLE;
        tmr_nxt       = '0;
      end
    endcase
  end

  always_comb begin
    c_nxt = (tmr_state == T_RUN) && bus.enable && !pres_s2 && (tmr == TW'(1));
  end

  logic a_q, b_q, c_q, d_q;

  // A mode toggle drops any coincident auto event rather than deferring it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= 1'b0;
      b_q <= 1'b0;
      c_q <= 1'b0;
      d_q <= 1'b0;
    end else begin
      a_q <= a_nxt;
      b_q <= b_nxt;
      c_q <= c_nxt & ~a_nxt;
      d_q <= d_nxt & ~a_nxt;
    end
  end

  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.c        = c_q;
  assign bus.d        = d_q;
  assign bus.tmr_busy = (tmr_state == T_RUN);

endmodule

// File: tb/tb_lamp_cmd_sequencer.sv
// Directed bench for lamp_cmd_sequencer with DB=4, LONG=20, HOLD=10.
module tb_lamp_cmd_sequencer;

  logic clk;
  logic rst;

  lamp_cmd_sequencer_if bus ();

  lamp_cmd_sequencer #(
    .DB_CYCLES   (4),
    .LONG_CYCLES (20),
    .HOLD_CYCLES (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int glitches;
    int len;
    int exp_a;
    int exp_b;
    int exp_a_cyc;
    int exp_b_cyc;
  } press_vec_t;

  int total;
  int passed;
  int cyc;
  int a_cnt, b_cnt, c_cnt, d_cnt;
  int a_first, b_first, c_first, d_first;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clear_counts();
    cyc = 0;
    a_cnt = 0; b_cnt = 0; c_cnt = 0; d_cnt = 0;
    a_first = 0; b_first = 0; c_first = 0; d_first = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.a) begin a_cnt++; if (a_first == 0) a_first = cyc; end
    if (bus.b) begin b_cnt++; if (b_first == 0) b_first = cyc; end
    if (bus.c) begin c_cnt++; if (c_first == 0) c_first = cyc; end
    if (bus.d) begin d_cnt++; if (d_first == 0) d_first = cyc; end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  press_vec_t vecs[7];

  initial begin
    total  = 0;
    passed = 0;
    clear_counts();

    // Raw press lengths equal debounced lengths when the input is clean.
    vecs[0] = '{glitches: 0, len: 12, exp_a: 0, exp_b: 1, exp_a_cyc: 0,  exp_b_cyc: 19};
    vecs[1] = '{glitches: 3, len: 12, exp_a: 0, exp_b: 1, exp_a_cyc: 0,  exp_b_cyc: 19};
    vecs[2] = '{glitches: 0, len: 40, exp_a: 1, exp_b: 0, exp_a_cyc: 26, exp_b_cyc: 0};
    vecs[3] = '{glitches: 0, len: 19, exp_a: 0, exp_b: 1, exp_a_cyc: 0,  exp_b_cyc: 26};
    vecs[4] = '{glitches: 0, len: 20, exp_a: 1, exp_b: 0, exp_a_cyc: 26, exp_b_cyc: 0};
    vecs[5] = '{glitches: 0, len: 3,  exp_a: 0, exp_b: 0, exp_a_cyc: 0,  exp_b_cyc: 0};
    vecs[6] = '{glitches: 0, len: 5,  exp_a: 0, exp_b: 1, exp_a_cyc: 0,  exp_b_cyc: 12};

    // Reset with button and sensor asserted.
    rst = 1'b1;
    bus.push = 1'b1;
    bus.presence = 1'b1;
    bus.enable = 1'b0;
    ticks(3);
    check("reset_outputs", int'({bus.a, bus.b, bus.c, bus.d, bus.tmr_busy}), 0);
    bus.presence = 1'b0;
    rst = 1'b0;
    clear_counts();
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 30) bus.push = 1'b0;
    end
    check("post_reset_a_cycle", a_first, 26);
    check("post_reset_a_count", a_cnt, 1);
    check("post_reset_b_count", b_cnt, 0);
    check("post_reset_d_count", d_cnt, 0);
    ticks(10);

    foreach (vecs[k]) begin
      for (int g = 0; g < vecs[k].glitches; g++) begin
        bus.push = 1'b1;
        tick();
        bus.push = 1'b0;
        tick();
      end
      clear_counts();
      bus.push = 1'b1;
      for (int i = 1; i <= vecs[k].len + 60; i++) begin
        tick();
        if (i == vecs[k].len) bus.push = 1'b0;
      end
      check($sformatf("press%0d_a_count", k), a_cnt, vecs[k].exp_a);
      check($sformatf("press%0d_b_count", k), b_cnt, vecs[k].exp_b);
      if (vecs[k].exp_a_cyc != 0) check($sformatf("press%0d_a_cycle", k), a_first, vecs[k].exp_a_cyc);
      if (vecs[k].exp_b_cyc != 0) check($sformatf("press%0d_b_cycle", k), b_first, vecs[k].exp_b_cyc);
    end

    // Hold timer: single presence pulse, then enable kept high after c.
    bus.enable = 1'b1;
    ticks(3);
    check("busy_after_enable", int'(bus.tmr_busy), 1);
    clear_counts();
    bus.presence = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 2) bus.presence = 1'b0;
      if (i == 13) check("busy_before_c", int'(bus.tmr_busy), 1);
      if (i == 14) check("busy_at_c", int'(bus.tmr_busy), 0);
    end
    check("hold_d_cycle", d_first, 3);
    check("hold_d_count", d_cnt, 1);
    check("hold_c_cycle", c_first, 14);
    check("hold_c_count", c_cnt, 1);
    bus.enable = 1'b0;
    ticks(3);

    // Presence re-asserted at count 3 reloads the timer.
    bus.enable = 1'b1;
    ticks(3);
    clear_counts();
    bus.presence = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (i == 2)  bus.presence = 1'b0;
      if (i == 11) bus.presence = 1'b1;
      if (i == 13) bus.presence = 1'b0;
    end
    check("reload_c_cycle", c_first, 25);
    check("reload_c_count", c_cnt, 1);
    check("reload_d_count", d_cnt, 2);
    bus.enable = 1'b0;
    ticks(3);

    // Enable falls while the count is 1.
    bus.enable = 1'b1;
    ticks(3);
    clear_counts();
    bus.presence = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 2) bus.presence = 1'b0;
      if (i == 13) begin
        check("busy_count1", int'(bus.tmr_busy), 1);
        bus.enable = 1'b0;
      end
      if (i == 14) check("busy_after_enable_fall", int'(bus.tmr_busy), 0);
    end
    check("enable_fall_c_count", c_cnt, 0);
    ticks(3);

    // Reset while the count is 5.
    bus.enable = 1'b1;
    ticks(3);
    clear_counts();
    bus.presence = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 2) bus.presence = 1'b0;
      if (i == 9) begin
        check("busy_count5", int'(bus.tmr_busy), 1);
        rst = 1'b1;
        bus.enable = 1'b0;
      end
      if (i == 10) check("busy_in_reset", int'(bus.tmr_busy), 0);
      if (i == 11) rst = 1'b0;
    end
    check("reset_hold_c_count", c_cnt, 0);
    check("reset_hold_busy", int'(bus.tmr_busy), 0);
    ticks(3);

    // Presence rise lands in the same cycle as a.
    clear_counts();
    bus.push = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (i == 23) bus.presence = 1'b1;
      if (i == 40) bus.push = 1'b0;
      if (i == 50) bus.presence = 1'b0;
    end
    check("collide_a_cycle", a_first, 26);
    check("collide_a_count", a_cnt, 1);
    check("collide_b_count", b_cnt, 0);
    check("collide_d_count", d_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
